// File: rtl/nabp_angle_sequencer_pkg.sv
// ============================================================================
// Module  : nabp_angle_sequencer_pkg
// Brief   : Shared constants, sector encodings and FSM state encoding for the
//           NABP projection-angle sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package nabp_angle_sequencer_pkg;

    localparam int kAngleLength = 9;
    localparam int kAngle45     = 45;
    localparam int kAngle90     = 90;
    localparam int kAngle135    = 135;
    localparam int kAngle180    = 180;

    typedef enum logic [1:0] {
        SECTOR_A = 2'd0,
        SECTOR_B = 2'd1,
        SECTOR_C = 2'd2,
        SECTOR_D = 2'd3
    } sector_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/nabp_angle_step_counter.sv
// ============================================================================
// Module  : nabp_angle_step_counter
// Brief   : Load/increment angle register with registered last-angle flag.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module nabp_angle_step_counter #(
    parameter int kAngleLength = nabp_angle_sequencer_pkg::kAngleLength,
    parameter int kAngleStart  = 0,
    parameter int kAngleStep   = 1,
    parameter int kAngleEnd    = nabp_angle_sequencer_pkg::kAngle180
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic                    incr_i,
    output logic [kAngleLength-1:0] angle_o,
    output logic [kAngleLength-1:0] angle_next_o,
    output logic                    last_angle_o
);
    import nabp_angle_sequencer_pkg::*;

    localparam logic [kAngleLength:0] kStartExt    = (kAngleLength+1)'(kAngleStart);
    localparam logic [kAngleLength:0] kStepExt     = (kAngleLength+1)'(kAngleStep);
    localparam logic [kAngleLength:0] kEndExt      = (kAngleLength+1)'(kAngleEnd);
    localparam logic                  kLastAtStart = ((kStartExt + kStepExt) >= kEndExt);

    logic [kAngleLength-1:0] angle_q;
    logic [kAngleLength-1:0] angle_d;
    logic                    last_q;
    logic                    last_d;
    logic [kAngleLength:0]   next_ext;

    // One extra bit on the sum keeps the end comparison free of wrap-around.
    always_comb begin
        next_ext = {1'b0, angle_q};
        if (load_i) begin
            next_ext = kStartExt;
        end else if (incr_i) begin
            next_ext = {1'b0, angle_q} + kStepExt;
        end
        angle_d = next_ext[kAngleLength-1:0];
        last_d  = ((next_ext + kStepExt) >= kEndExt);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            angle_q <= kStartExt[kAngleLength-1:0];
            last_q  <= kLastAtStart;
        end else begin
            angle_q <= angle_d;
            last_q  <= last_d;
        end
    end

    assign angle_o      = angle_q;
    assign angle_next_o = angle_d;
    assign last_angle_o = last_q;

endmodule

`default_nettype wire

// File: rtl/nabp_angle_sequencer.sv
// ============================================================================
// Module  : nabp_angle_sequencer
// Brief   : Steps the projection angle through a sweep with valid/ready issue
//           and done-driven advance; reports sector and sector-change strobe.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module nabp_angle_sequencer #(
    parameter int kAngleLength = nabp_angle_sequencer_pkg::kAngleLength,
    parameter int kAngleStart  = 0,
    parameter int kAngleStep   = 1,
    parameter int kAngleEnd    = nabp_angle_sequencer_pkg::kAngle180,
    parameter int kAngle45     = nabp_angle_sequencer_pkg::kAngle45,
    parameter int kAngle90     = nabp_angle_sequencer_pkg::kAngle90,
    parameter int kAngle135    = nabp_angle_sequencer_pkg::kAngle135
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    angle_ready_i,
    input  logic                    angle_done_i,
    output logic [kAngleLength-1:0] angle_o,
    output logic                    angle_valid_o,
    output logic [1:0]              sector_o,
    output logic                    sector_start_o,
    output logic                    last_angle_o,
    output logic                    busy_o,
    output logic                    done_o
);
    import nabp_angle_sequencer_pkg::*;

    if ((kAngleStart >= kAngleEnd) || (kAngleStep < 1)) begin : g_bad_sweep
        $error("nabp_angle_sequencer: illegal sweep (start >= end or step < 1)");
    end

    localparam logic [kAngleLength-1:0] kT45   = kAngleLength'(kAngle45);
    localparam logic [kAngleLength-1:0] kT90   = kAngleLength'(kAngle90);
    localparam logic [kAngleLength-1:0] kT135  = kAngleLength'(kAngle135);
    localparam logic [kAngleLength-1:0] kStart = kAngleLength'(kAngleStart);

    function automatic sector_e sector_of(input logic [kAngleLength-1:0] a);
        if (a < kT45)       return SECTOR_A;
        else if (a < kT90)  return SECTOR_B;
        else if (a < kT135) return SECTOR_C;
        else                return SECTOR_D;
    endfunction

    state_e                  state_q, state_d;
    sector_e                 sector_q, sector_next;
    logic                    sector_start_q, sector_start_d;
    logic                    load, incr;
    logic                    last_angle;
    logic [kAngleLength-1:0] angle_next;

    nabp_angle_step_counter #(
        .kAngleLength (kAngleLength),
        .kAngleStart  (kAngleStart),
        .kAngleStep   (kAngleStep),
        .kAngleEnd    (kAngleEnd)
    ) u_counter (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_i       (load),
        .incr_i       (incr),
        .angle_o      (angle_o),
        .angle_next_o (angle_next),
        .last_angle_o (last_angle)
    );

    // abort wins over both the handshake and angle_done in the same cycle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        incr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    load    = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (abort_i)            state_d = ST_IDLE;
                else if (angle_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (angle_done_i) begin
                    if (last_angle) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                        incr    = 1'b1;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign sector_next    = sector_of(angle_next);
    assign sector_start_d = load | (incr & (sector_next != sector_q));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            sector_q       <= sector_of(kStart);
            sector_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sector_q       <= sector_next;
            sector_start_q <= sector_start_d;
        end
    end

    assign angle_valid_o  = (state_q == ST_ISSUE);
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_FINISH);
    assign sector_o       = sector_q;
    assign sector_start_o = sector_start_q;
    assign last_angle_o   = last_angle;

endmodule

`default_nettype wire

// File: tb/tb_nabp_angle_sequencer.sv
// ============================================================================
// Module  : tb_nabp_angle_sequencer
// Brief   : Directed self-checking bench for three sequencer configurations.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nabp_angle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start [3];
    logic       abort [3];
    logic       ready [3];
    logic       adone [3];
    logic [8:0] angle [3];
    logic       valid [3];
    logic [1:0] sector[3];
    logic       ss    [3];
    logic       last  [3];
    logic       busy  [3];
    logic       done  [3];

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int prev_sector;
    int dut_ss;
    int hs_count;
    int last_a;
    int cfg_step [3] = '{1, 45, 20};
    int cfg_start[3] = '{0, 0, 170};

    always #5 clk = ~clk;

    nabp_angle_sequencer #(.kAngleStep(1)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .start_i(start[0]), .abort_i(abort[0]),
        .angle_ready_i(ready[0]), .angle_done_i(adone[0]), .angle_o(angle[0]),
        .angle_valid_o(valid[0]), .sector_o(sector[0]), .sector_start_o(ss[0]),
        .last_angle_o(last[0]), .busy_o(busy[0]), .done_o(done[0]));

    nabp_angle_sequencer #(.kAngleStep(45)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start[1]), .abort_i(abort[1]),
        .angle_ready_i(ready[1]), .angle_done_i(adone[1]), .angle_o(angle[1]),
        .angle_valid_o(valid[1]), .sector_o(sector[1]), .sector_start_o(ss[1]),
        .last_angle_o(last[1]), .busy_o(busy[1]), .done_o(done[1]));

    nabp_angle_sequencer #(.kAngleStart(170), .kAngleStep(20)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .start_i(start[2]), .abort_i(abort[2]),
        .angle_ready_i(ready[2]), .angle_done_i(adone[2]), .angle_o(angle[2]),
        .angle_valid_o(valid[2]), .sector_o(sector[2]), .sector_start_o(ss[2]),
        .last_angle_o(last[2]), .busy_o(busy[2]), .done_o(done[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_sector(input int a);
        if (a < 45)  return 0;
        if (a < 90)  return 1;
        if (a < 135) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int idx);
        chk("rst_angle",  32'(angle[idx]),  32'(cfg_start[idx]));
        chk("rst_valid",  32'(valid[idx]),  0);
        chk("rst_sector", 32'(sector[idx]), 32'(model_sector(cfg_start[idx])));
        chk("rst_ss",     32'(ss[idx]),     0);
        chk("rst_last",   32'(last[idx]),   32'(cfg_start[idx] + cfg_step[idx] >= 180));
        chk("rst_busy",   32'(busy[idx]),   0);
        chk("rst_done",   32'(done[idx]),   0);
    endtask

    // Entered at the sample point of an ISSUE cycle with ready held high.
    task automatic serve(input int idx, input bit do_done);
        int a;
        int s;
        if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
            a = -1;
        end else begin
            a = exp_q.pop_front();
        end
        s = model_sector(a);
        if (valid[idx] && ready[idx]) hs_count++;
        if (ss[idx]) dut_ss++;
        chk("issue_valid",  32'(valid[idx]),  1);
        chk("angle",        32'(angle[idx]),  32'(a));
        chk("sector",       32'(sector[idx]), 32'(s));
        chk("last_angle",   32'(last[idx]),   32'(a + cfg_step[idx] >= 180));
        chk("sector_start", 32'(ss[idx]),     32'(s != prev_sector));
        prev_sector = s;
        last_a = a;
        tick();
        chk("wait_valid", 32'(valid[idx]), 0);
        chk("wait_ss",    32'(ss[idx]),    0);
        tick();
        tick();
        if (do_done) begin
            adone[idx] = 1'b1;
            tick();
            adone[idx] = 1'b0;
        end
    endtask

    task automatic sweep(input int idx);
        int n;
        for (int a = cfg_start[idx]; a < 180; a += cfg_step[idx]) exp_q.push_back(a);
        n = exp_q.size();
        prev_sector = -1;
        dut_ss = 0;
        hs_count = 0;
        ready[idx] = 1'b1;
        start[idx] = 1'b1;
        tick();
        start[idx] = 1'b0;
        for (int i = 0; i < n; i++) serve(idx, 1'b1);
        chk("done_pulse",  32'(done[idx]),  1);
        chk("done_busy",   32'(busy[idx]),  1);
        chk("done_valid",  32'(valid[idx]), 0);
        tick();
        chk("done_once",   32'(done[idx]),  0);
        chk("idle_busy",   32'(busy[idx]),  0);
        chk("hold_angle",  32'(angle[idx]), 32'(last_a));
        chk("queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; ready[i] = 1'b0; adone[i] = 1'b0;
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) check_reset(i);

        // Step 45: four angles, one per sector.
        sweep(1);
        chk("s45_ss_count", 32'(dut_ss), 4);
        chk("s45_handshakes", 32'(hs_count), 4);

        // Ready stall at angle 0.
        exp_q.push_back(0);
        prev_sector = -1;
        dut_ss = 0;
        hs_count = 0;
        ready[0] = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("stall_first_ss", 32'(ss[0]), 1);
        prev_sector = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(valid[0]), 1);
            chk("stall_angle", 32'(angle[0]), 0);
            chk("stall_busy",  32'(busy[0]),  1);
            tick();
        end
        ready[0] = 1'b1;
        serve(0, 1'b1);
        for (int a = 1; a <= 30; a++) exp_q.push_back(a);
        for (int a = 1; a < 30; a++) serve(0, 1'b1);
        serve(0, 1'b0);

        // Abort in WAIT at angle 30 together with angle_done.
        abort[0] = 1'b1;
        adone[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        adone[0] = 1'b0;
        chk("abort_busy",  32'(busy[0]),  0);
        chk("abort_valid", 32'(valid[0]), 0);
        chk("abort_done",  32'(done[0]),  0);
        chk("abort_angle", 32'(angle[0]), 30);
        tick();
        chk("abort_no_done", 32'(done[0]), 0);

        // Restart, ignore a start while busy, then reset at angle 100.
        for (int a = 0; a < 100; a++) exp_q.push_back(a);
        prev_sector = -1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int a = 0; a < 100; a++) begin
            start[0] = (a == 50);
            serve(0, 1'b1);
        end
        start[0] = 1'b0;
        chk("pre_reset_angle", 32'(angle[0]), 100);
        chk("pre_reset_valid", 32'(valid[0]), 1);
        start[0] = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start[0] = 1'b0;
        check_reset(0);
        tick();
        chk("post_reset_idle", 32'(busy[0]), 0);

        // Full step-1 sweep.
        sweep(0);
        chk("s1_ss_count",   32'(dut_ss),   4);
        chk("s1_handshakes", 32'(hs_count), 180);
        chk("s1_final",      32'(last_a),   179);

        // Single-angle sweep starting at 170.
        sweep(2);
        chk("s170_ss_count", 32'(dut_ss), 1);
        chk("s170_handshakes", 32'(hs_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
